// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one single-port character RAM between a write and a read client.
// Optional power-on clear to ASCII space is enabled by defining RAM_ARB_CLR_EN (adds init_done).
`default_nettype none

module ram_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_w,
  input  logic [DATA_W-1:0] ram_data_r
`ifdef RAM_ARB_CLR_EN
  ,
  output logic              init_done
`endif
);

  localparam logic [DATA_W-1:0] C_CLR_CHAR = DATA_W'(8'h20);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_CLR  = 2'd3
  } state_t;

  state_t state_q;
  logic   last_wr_q;   // 1: write client was served most recently
  logic   rd_valid_q;

`ifdef RAM_ARB_CLR_EN
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              init_done_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef RAM_ARB_CLR_EN
      state_q     <= S_CLR;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
`else
      state_q     <= S_IDLE;
`endif
      last_wr_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_valid_q <= (state_q == S_RD);
      case (state_q)
        S_IDLE: begin
          // On a tie the client that was not served last wins
          if (wr_req && (!rd_req || !last_wr_q)) state_q <= S_WR;
          else if (rd_req)                       state_q <= S_RD;
        end
        S_WR: begin
          last_wr_q <= 1'b1;
          state_q   <= rd_req ? S_RD : S_IDLE;
        end
        S_RD: begin
          last_wr_q <= 1'b0;
          state_q   <= wr_req ? S_WR : S_IDLE;
        end
        default: begin
`ifdef RAM_ARB_CLR_EN
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (&clr_cnt_q) begin
            state_q     <= S_IDLE;
            init_done_q <= 1'b1;
          end
`else
          state_q <= S_IDLE;
`endif
        end
      endcase
    end
  end

  // A cycle with rst high never commits a write or issues an ack
  always_comb begin
    wr_ack     = 1'b0;
    rd_ack     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_data_w = '0;
    if (!rst) begin
      case (state_q)
        S_WR: begin
          ram_we     = 1'b1;
          ram_addr   = wr_addr;
          ram_data_w = wr_data;
          wr_ack     = 1'b1;
        end
        S_RD: begin
          ram_addr = rd_addr;
          rd_ack   = 1'b1;
        end
`ifdef RAM_ARB_CLR_EN
        S_CLR: begin
          ram_we     = 1'b1;
          ram_addr   = clr_cnt_q;
          ram_data_w = C_CLR_CHAR;
        end
`endif
        default: ;
      endcase
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? ram_data_r : '0;

`ifdef RAM_ARB_CLR_EN
  assign init_done = init_done_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed + random stimulus against a cycle-level grant/memory reference model.
`default_nettype none

module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req, rd_req;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic       wr_ack, rd_ack, rd_valid, ram_we;
  logic [7:0] rd_data, ram_data_w, ram_data_r;
  logic [3:0] ram_addr;
`ifdef RAM_ARB_CLR_EN
  logic       init_done;
`endif

  always #5 clk = ~clk;

  ram_arbiter #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data_w (ram_data_w),
    .ram_data_r (ram_data_r)
`ifdef RAM_ARB_CLR_EN
    ,
    .init_done  (init_done)
`endif
  );

  // Single-port RAM with registered read (read-before-write)
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data_w;
    ram_data_r <= mem[ram_addr];
  end

  // Reference model: shadow memory, previous-cycle grant and inputs
  logic [7:0] exp_mem [16];
  int         g_prev;   // 0 none, 1 write, 2 read
  bit         last_w;
  logic       p_wreq, p_rreq;
  logic [3:0] p_waddr, p_raddr;
  logic [7:0] p_wdata;
  logic [7:0] cap;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_idle();
    g_prev = 0; last_w = 1'b0;
    p_wreq = 1'b0; p_rreq = 1'b0; p_waddr = '0; p_raddr = '0; p_wdata = '0;
  endtask

  // One cycle: model the grant from last cycle's requests, drive, then check
  task automatic step(input logic wq, input logic [3:0] wa, input logic [7:0] wd,
                      input logic rq, input logic [3:0] ra);
    int g; bit ew, er, vld; logic [7:0] vexp;
    @(posedge clk);
    if (g_prev == 1) exp_mem[p_waddr] = p_wdata;
    vld  = (g_prev == 2);
    vexp = cap;
    ew = p_wreq && (g_prev != 1);
    er = p_rreq && (g_prev != 2);
    if (ew && er)  g = last_w ? 2 : 1;
    else if (ew)   g = 1;
    else if (er)   g = 2;
    else           g = 0;
    if (g == 1) last_w = 1'b1;
    else if (g == 2) last_w = 1'b0;
    #1;
    wr_req = wq; wr_addr = wa; wr_data = wd; rd_req = rq; rd_addr = ra;
    if (g == 2) cap = exp_mem[ra];
    @(negedge clk);
    check("wr_ack", wr_ack, g == 1);
    check("rd_ack", rd_ack, g == 2);
    check("ram_we", ram_we, g == 1);
    check("ram_addr", ram_addr, (g == 1) ? wa : (g == 2) ? ra : 4'd0);
    check("ram_data_w", ram_data_w, (g == 1) ? wd : 8'd0);
    check("rd_valid", rd_valid, vld);
    check("rd_data", rd_data, vld ? vexp : 8'd0);
    p_wreq = wq; p_waddr = wa; p_wdata = wd; p_rreq = rq; p_raddr = ra;
    g_prev = g;
  endtask

`ifdef RAM_ARB_CLR_EN
  task automatic clr_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("clr_we", ram_we, 1'b1);
      check("clr_addr", ram_addr, i[3:0]);
      check("clr_data", ram_data_w, 8'h20);
      check("clr_ack", {wr_ack, rd_ack}, 2'b00);
      check("clr_init_done", init_done, 1'b0);
      @(posedge clk); #1;
    end
  endtask
`endif

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (i == 0 && g_prev == 1) exp_mem[p_waddr] = p_wdata;
      #1;
      rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0;
      @(negedge clk);
      check("rst_acks", {wr_ack, rd_ack, ram_we}, 3'b000);
      if (i > 0) begin
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 8'd0);
        check("rst_ram_addr", ram_addr, 4'd0);
        check("rst_ram_data_w", ram_data_w, 8'd0);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_idle();
`ifdef RAM_ARB_CLR_EN
    clr_check(16);
    for (int a = 0; a < 16; a++) exp_mem[a] = 8'h20;
    @(negedge clk);
    check("init_done", init_done, 1'b1);
    check("post_clr_we", ram_we, 1'b0);
`else
    @(negedge clk);
    check("idle_outputs", {wr_ack, rd_ack, rd_valid, ram_we, ram_addr, ram_data_w, rd_data},
          '0);
`endif
  endtask

  initial begin
    logic       wq, rq;
    logic [3:0] wa, ra;
    logic [7:0] wd;
    for (int a = 0; a < 16; a++) begin mem[a] = 8'h00; exp_mem[a] = 8'h00; end
    cap = '0;
    model_idle();
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    do_reset(3);

`ifdef RAM_ARB_CLR_EN
    // Clear interrupted part-way restarts from address 0
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    clr_check(6);
    do_reset(1);
`endif

    // Write 0x41 @3, then read it back
    step(1'b1, 4'd3, 8'h41, 1'b0, 4'd0);
    step(1'b1, 4'd3, 8'h41, 1'b0, 4'd0);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);

    // Both held continuously: tie to write first, then strict alternation
    for (int i = 0; i < 9; i++) step(1'b1, 4'd7, 8'hA5, 1'b1, 4'd7);
    for (int i = 0; i < 2; i++) step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);

    // Read-then-write same address returns the old value; later read the new one
    step(1'b1, 4'd5, 8'h10, 1'b0, 4'd0);
    step(1'b1, 4'd5, 8'h10, 1'b0, 4'd0);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
    step(1'b1, 4'd5, 8'h99, 1'b1, 4'd5);
    step(1'b1, 4'd5, 8'h99, 1'b0, 4'd0);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);

    // Write-only client held for 6 cycles
    for (int i = 0; i < 6; i++) step(1'b1, 4'd9, 8'h3C, 1'b0, 4'd0);
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);

    // Random traffic obeying the hold-until-ack protocol, with a mid-run reset
    wq = 1'b0; rq = 1'b0; wa = '0; ra = '0; wd = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) begin
        do_reset(2);
        wq = 1'b0; rq = 1'b0;
      end
      if (!wq || g_prev == 1) begin
        wq = 1'($urandom_range(0, 1));
        wa = 4'($urandom_range(0, 15));
        wd = 8'($urandom);
      end
      if (!rq || g_prev == 2) begin
        rq = ($urandom_range(0, 3) != 0);
        ra = 4'($urandom_range(0, 15));
      end
      step(wq, wa, wd, rq, ra);
    end
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one 16x8 single-port LCD character RAM between two clients: a write client (host/command path) and a read client (LCD refresh scanner).
- Sits directly in front of the RAM and drives its data_w/addr/we inputs. The RAM registers its read address, so read data is valid one cycle after the address is presented.
- Grants one access at a time through a small FSM with round-robin fairness. Returns read data with a valid strobe.

Parameters:
- DATA_W, 8, RAM data width
- ADDR_W, 4, RAM address width (depth 2**ADDR_W)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_req  in  1  write client requests an access; held with wr_addr/wr_data until wr_ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle pulse: write performed this cycle
- rd_req  in  1  read client requests an access; held with rd_addr until rd_ack
- rd_addr  in  ADDR_W  read address
- rd_ack  out  1  one-cycle pulse: read address presented to RAM this cycle
- rd_valid  out  1  one-cycle pulse, cycle after rd_ack
- rd_data  out  DATA_W  read data, meaningful only when rd_valid=1
- ram_we  out  1  to RAM we
- ram_addr  out  ADDR_W  to RAM addr
- ram_data_w  out  DATA_W  to RAM data_w
- ram_data_r  in  DATA_W  from RAM data_r

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- States:
  - IDLE: no access.
  - WR: write granted.
  - RD: read granted.
- Registered state plus a last-served flag (last).
- Reset: state=IDLE, last=RD (a tie after reset goes to write); rd_valid=0. All outputs are 0: wr_ack, rd_ack, rd_valid, ram_we, ram_addr, ram_data_w, rd_data.
- IDLE transitions:
  - Only wr_req -> WR.
  - Only rd_req -> RD.
  - Both -> the client not equal to last.
  - Neither -> IDLE.
- WR state:
  - Outputs: ram_we=1, ram_addr=wr_addr, ram_data_w=wr_data, wr_ack=1.
  - last<=WR.
  - Next: RD if rd_req, else IDLE.
- RD state:
  - Outputs: ram_we=0, ram_addr=rd_addr, rd_ack=1.
  - last<=RD.
  - Next: WR if wr_req, else IDLE.
- Request consumption: the request is consumed in its ack cycle. A client is never granted in two consecutive cycles, so a client that keeps req high gets back-to-back service only every second cycle.
- Read latency: rd_valid is a register set to rd_ack, so it is high exactly the cycle after RD. rd_data=ram_data_r (combinational pass-through) in that cycle, otherwise 0.
- rd_valid is independent of the current state and may coincide with WR.
- Read then write to the same address in the next cycle: the read returns the pre-write value, because the write commits at the end of the rd_valid cycle.
- Write then read to the same address: the read returns the new value.
- Idle outputs: ram_we=0 and ram_addr=0 in IDLE; ram_data_w=0 outside WR.
- Protocol violations: a client changing addr/data while req is high before ack is a protocol violation and is not detected. Dropping req before ack withdraws the request; no ack is issued.
- Reset asserted mid-access: the access is aborted; no ack, and rd_valid=0 in the following cycle. A write in progress still commits only if its cycle completed without rst.

Optional Feature:
- Macro: RAM_ARB_CLR_EN.
- When defined:
  - Adds output init_done (1 bit) and state CLR.
  - Reset enters CLR with clear counter=0 and init_done=0.
  - Each CLR cycle: ram_we=1, ram_addr=counter, ram_data_w=8'h20 (ASCII space), counter+1.
  - After address 2**ADDR_W-1, go to IDLE and set init_done=1. The clear therefore takes 2**ADDR_W cycles.
  - During CLR, wr_ack=rd_ack=0; requests wait.
  - rst during CLR restarts the clear from address 0.
- When undefined: no CLR state, no init_done port, and reset goes directly to IDLE with RAM contents untouched.

Test Plan:
- Reset, then write 0x41 to addr 3 (wr_req 1 cycle after reset) -> wr_ack in the next cycle with ram_we=1, ram_addr=3, ram_data_w=0x41. Then read addr 3 -> rd_ack, then rd_valid=1 with rd_data=0x41 one cycle later.
- wr_req and rd_req both high from IDLE after reset -> WR granted first, then RD in the next cycle; no IDLE cycle between them.
- Both clients hold req continuously for 8 cycles -> strict alternation W,R,W,R…; 4 wr_ack and 4 rd_ack; each rd_valid exactly 1 cycle after its rd_ack.
- addr 5 holds 0x10: read addr 5, then write 0x99 to addr 5 in the next cycle -> rd_data=0x10 during the rd_valid cycle (same cycle as wr_ack). A subsequent read returns 0x99.
- Only wr_req held high for 6 cycles -> wr_ack every second cycle (3 acks), IDLE in between, rd_ack never asserted.
- (RAM_ARB_CLR_EN) Release reset -> 16 cycles of ram_we=1 at addr 0..15 with data 0x20, then init_done=1. A wr_req held during the clear is acked only after init_done rises. Reasserting rst at the 7th clear cycle restarts the clear at addr 0.
